// File: rtl/fwd_hazard_unit.sv
// Pipeline hazard unit for the 5-stage core: M/W -> E operand forwarding,
// load-use (or legacy stall-until-writeback) data stalls, a multi-cycle
// branch flush sequencer and a saturating stall watchdog.
module fwd_hazard_unit #(
    parameter int ADDR_W     = 4,
    parameter int FWD_EN     = 1,
    parameter int BR_PENALTY = 2,
    parameter int CNT_W      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] i_RA1_D,
    input  logic [ADDR_W-1:0] i_RA2_D,
    input  logic [ADDR_W-1:0] i_RA1_E,
    input  logic [ADDR_W-1:0] i_RA2_E,
    input  logic              i_RegWrite_E,
    input  logic              i_MemtoReg_E,
    input  logic [ADDR_W-1:0] i_WA3_E,
    input  logic              i_RegWrite_M,
    input  logic [ADDR_W-1:0] i_WA3_M,
    input  logic              i_RegWrite_W,
    input  logic [ADDR_W-1:0] i_WA3_W,
    input  logic              i_PCSrc_E,
    output logic [1:0]        o_FwdA_E,
    output logic [1:0]        o_FwdB_E,
    output logic              o_StallF,
    output logic              o_StallD,
    output logic              o_FlushD,
    output logic              o_FlushE,
    output logic [CNT_W-1:0]  o_StallCnt,
    output logic              o_Timeout
);

    typedef enum logic {BR_IDLE, BR_FLUSH} br_state_t;

    localparam logic [3:0]       BR_RELOAD = 4'(BR_PENALTY - 1);
    localparam logic [3:0]       BR_ONE    = 4'd1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    br_state_t        br_state;
    logic [3:0]       br_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] stall_inc;
    logic             timeout;
    logic             data_stall;
    logic             br_flush;
    logic             stall_d;

    // The PC register (all-ones address) is never a forwarding or hazard source.
    function automatic logic reg_match(input logic [ADDR_W-1:0] src,
                                       input logic              we,
                                       input logic [ADDR_W-1:0] wa);
        return we && (wa == src) && (src != {ADDR_W{1'b1}});
    endfunction

    // Operand forwarding selects; M is the younger result so it wins over W.
    always_comb begin
        o_FwdA_E = 2'b00;
        o_FwdB_E = 2'b00;
        if (FWD_EN != 0 && !reset) begin
            if (reg_match(i_RA1_E, i_RegWrite_M, i_WA3_M))
                o_FwdA_E = 2'b10;
            else if (reg_match(i_RA1_E, i_RegWrite_W, i_WA3_W))
                o_FwdA_E = 2'b01;
            if (reg_match(i_RA2_E, i_RegWrite_M, i_WA3_M))
                o_FwdB_E = 2'b10;
            else if (reg_match(i_RA2_E, i_RegWrite_W, i_WA3_W))
                o_FwdB_E = 2'b01;
        end
    end

    // Data stall detection, then branch flush overriding the stall.
    always_comb begin
        if (FWD_EN != 0) begin
            data_stall = i_MemtoReg_E &&
                         (reg_match(i_RA1_D, i_RegWrite_E, i_WA3_E) ||
                          reg_match(i_RA2_D, i_RegWrite_E, i_WA3_E));
        end else begin
            data_stall = reg_match(i_RA1_D, i_RegWrite_E, i_WA3_E) ||
                         reg_match(i_RA2_D, i_RegWrite_E, i_WA3_E) ||
                         reg_match(i_RA1_D, i_RegWrite_M, i_WA3_M) ||
                         reg_match(i_RA2_D, i_RegWrite_M, i_WA3_M) ||
                         reg_match(i_RA1_D, i_RegWrite_W, i_WA3_W) ||
                         reg_match(i_RA2_D, i_RegWrite_W, i_WA3_W);
        end
        br_flush = i_PCSrc_E || (br_state == BR_FLUSH);
        stall_d  = !reset && data_stall && !br_flush;
        o_StallF = stall_d;
        o_StallD = stall_d;
        o_FlushD = !reset && br_flush;
        o_FlushE = !reset && (br_flush || data_stall);
    end

    // Branch flush sequencer: holds the flush for BR_PENALTY cycles, restarting on a new branch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            br_state <= BR_IDLE;
            br_cnt   <= 4'd0;
        end else begin
            case (br_state)
                BR_IDLE: begin
                    if (i_PCSrc_E && BR_PENALTY > 1) begin
                        br_cnt   <= BR_RELOAD;
                        br_state <= BR_FLUSH;
                    end
                end
                BR_FLUSH: begin
                    if (i_PCSrc_E) begin
                        br_cnt <= BR_RELOAD;
                    end else if (br_cnt == BR_ONE) begin
                        br_cnt   <= 4'd0;
                        br_state <= BR_IDLE;
                    end else begin
                        br_cnt <= br_cnt - BR_ONE;
                    end
                end
                default: begin
                    br_cnt   <= 4'd0;
                    br_state <= BR_IDLE;
                end
            endcase
        end
    end

    assign stall_inc = (stall_cnt == {CNT_W{1'b1}}) ? stall_cnt : stall_cnt + CNT_ONE;

    // Stall watchdog: counts consecutive stalled cycles; timeout tracks the saturated count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            timeout   <= 1'b0;
        end else if (stall_d) begin
            stall_cnt <= stall_inc;
            timeout   <= (stall_inc == {CNT_W{1'b1}});
        end else begin
            stall_cnt <= '0;
            timeout   <= 1'b0;
        end
    end

    assign o_StallCnt = stall_cnt;
    assign o_Timeout  = timeout;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: instance A (forwarding, BR_PENALTY=3) and
// instance B (legacy stall mode, CNT_W=2) share one set of inputs.
module tb_fwd_hazard_unit;

    typedef struct packed {
        logic [3:0] ra1_d, ra2_d, ra1_e, ra2_e;
        logic       rw_e, mtr_e;
        logic [3:0] wa_e;
        logic       rw_m;
        logic [3:0] wa_m;
        logic       rw_w;
        logic [3:0] wa_w;
        logic       pcsrc;
    } in_t;

    typedef struct packed {
        logic [1:0] fa, fb;
        logic       sf, sd, fd, fe;
        logic [3:0] cnt;
        logic       to;
    } exp_t;

    typedef struct {
        string name;
        int    dut;
        exp_t  e;
    } sb_t;

    typedef struct {
        string name;
        in_t   v;
        exp_t  e;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    in_t  vin;

    logic [1:0] fa_a, fb_a, fa_b, fb_b;
    logic       sf_a, sd_a, fd_a, fe_a, to_a;
    logic       sf_b, sd_b, fd_b, fe_b, to_b;
    logic [3:0] cnt_a;
    logic [1:0] cnt_b;

    int   n_vec = 0;
    int   n_bad = 0;
    sb_t  sbq[$];
    vec_t tbl[12];

    always #5 clk = ~clk;

    fwd_hazard_unit #(.ADDR_W(4), .FWD_EN(1), .BR_PENALTY(3), .CNT_W(4)) dut_a (
        .clk(clk), .reset(reset),
        .i_RA1_D(vin.ra1_d), .i_RA2_D(vin.ra2_d), .i_RA1_E(vin.ra1_e), .i_RA2_E(vin.ra2_e),
        .i_RegWrite_E(vin.rw_e), .i_MemtoReg_E(vin.mtr_e), .i_WA3_E(vin.wa_e),
        .i_RegWrite_M(vin.rw_m), .i_WA3_M(vin.wa_m),
        .i_RegWrite_W(vin.rw_w), .i_WA3_W(vin.wa_w), .i_PCSrc_E(vin.pcsrc),
        .o_FwdA_E(fa_a), .o_FwdB_E(fb_a), .o_StallF(sf_a), .o_StallD(sd_a),
        .o_FlushD(fd_a), .o_FlushE(fe_a), .o_StallCnt(cnt_a), .o_Timeout(to_a)
    );

    fwd_hazard_unit #(.ADDR_W(4), .FWD_EN(0), .BR_PENALTY(3), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset),
        .i_RA1_D(vin.ra1_d), .i_RA2_D(vin.ra2_d), .i_RA1_E(vin.ra1_e), .i_RA2_E(vin.ra2_e),
        .i_RegWrite_E(vin.rw_e), .i_MemtoReg_E(vin.mtr_e), .i_WA3_E(vin.wa_e),
        .i_RegWrite_M(vin.rw_m), .i_WA3_M(vin.wa_m),
        .i_RegWrite_W(vin.rw_w), .i_WA3_W(vin.wa_w), .i_PCSrc_E(vin.pcsrc),
        .o_FwdA_E(fa_b), .o_FwdB_E(fb_b), .o_StallF(sf_b), .o_StallD(sd_b),
        .o_FlushD(fd_b), .o_FlushE(fe_b), .o_StallCnt(cnt_b), .o_Timeout(to_b)
    );

    function automatic in_t mk(int ra1_d, int ra2_d, int ra1_e, int ra2_e,
                               int rw_e, int mtr_e, int wa_e, int rw_m, int wa_m,
                               int rw_w, int wa_w, int pcsrc);
        in_t v;
        v.ra1_d = 4'(ra1_d); v.ra2_d = 4'(ra2_d);
        v.ra1_e = 4'(ra1_e); v.ra2_e = 4'(ra2_e);
        v.rw_e  = 1'(rw_e);  v.mtr_e = 1'(mtr_e); v.wa_e = 4'(wa_e);
        v.rw_m  = 1'(rw_m);  v.wa_m  = 4'(wa_m);
        v.rw_w  = 1'(rw_w);  v.wa_w  = 4'(wa_w);
        v.pcsrc = 1'(pcsrc);
        return v;
    endfunction

    function automatic exp_t mx(int fa, int fb, int sf, int sd, int fd, int fe, int cnt, int to);
        exp_t e;
        e.fa = 2'(fa); e.fb = 2'(fb);
        e.sf = 1'(sf); e.sd = 1'(sd); e.fd = 1'(fd); e.fe = 1'(fe);
        e.cnt = 4'(cnt); e.to = 1'(to);
        return e;
    endfunction

    function automatic exp_t act(int dut);
        exp_t a;
        if (dut == 0) a = {fa_a, fb_a, sf_a, sd_a, fd_a, fe_a, cnt_a, to_a};
        else          a = {fa_b, fb_b, sf_b, sd_b, fd_b, fe_b, 2'b00, cnt_b, to_b};
        return a;
    endfunction

    task automatic push(string nm, int dut, exp_t e);
        sb_t s;
        s.name = nm; s.dut = dut; s.e = e;
        sbq.push_back(s);
    endtask

    task automatic drain();
        while (sbq.size() > 0) begin
            sb_t  s;
            exp_t a;
            s = sbq.pop_front();
            a = act(s.dut);
            n_vec++;
            if (a !== s.e) begin
                n_bad++;
                $display("FAIL %s dut%0d: got fa=%b fb=%b sf=%b sd=%b fd=%b fe=%b cnt=%0d to=%b, want fa=%b fb=%b sf=%b sd=%b fd=%b fe=%b cnt=%0d to=%b",
                         s.name, s.dut, a.fa, a.fb, a.sf, a.sd, a.fd, a.fe, a.cnt, a.to,
                         s.e.fa, s.e.fb, s.e.sf, s.e.sd, s.e.fd, s.e.fe, s.e.cnt, s.e.to);
            end
        end
    endtask

    // One cycle: drive at posedge+1, check at negedge, end at next posedge+1.
    task automatic cyc(string nm, int dut, in_t v, exp_t e);
        vin = v;
        push(nm, dut, e);
        @(negedge clk);
        drain();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout: got no finish, want finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        in_t  idle;
        in_t  busy;
        exp_t z;
        idle = '0;
        z    = '0;
        busy = mk(6, 6, 1, 1, 1, 1, 6, 1, 1, 1, 1, 1);

        // table of single-cycle vectors for the forwarding instance
        tbl[0]  = '{"fwdA_M_over_W", mk(0,0,1,0, 0,0,0, 1,1, 1,1, 0), mx(2,0, 0,0,0,0, 0,0)};
        tbl[1]  = '{"fwdA_W",        mk(0,0,1,0, 0,0,0, 0,0, 1,1, 0), mx(1,0, 0,0,0,0, 0,0)};
        tbl[2]  = '{"fwdB_pc",       mk(0,0,0,15, 0,0,0, 1,15, 1,15, 0), mx(0,0, 0,0,0,0, 0,0)};
        tbl[3]  = '{"fwdB_M",        mk(0,0,0,7, 0,0,0, 1,7, 0,0, 0), mx(0,2, 0,0,0,0, 0,0)};
        tbl[4]  = '{"fwd_no_we",     mk(0,0,3,3, 0,0,0, 0,3, 0,3, 0), mx(0,0, 0,0,0,0, 0,0)};
        tbl[5]  = '{"fwd_mix",       mk(0,0,4,5, 0,0,0, 1,5, 1,4, 0), mx(1,2, 0,0,0,0, 0,0)};
        tbl[6]  = '{"ld_not_load",   mk(0,2,0,0, 1,0,2, 0,0, 0,0, 0), mx(0,0, 0,0,0,0, 0,0)};
        tbl[7]  = '{"ld_pc",         mk(15,0,0,0, 1,1,15, 0,0, 0,0, 0), mx(0,0, 0,0,0,0, 0,0)};
        tbl[8]  = '{"ld_no_we",      mk(2,0,0,0, 0,1,2, 0,0, 0,0, 0), mx(0,0, 0,0,0,0, 0,0)};
        tbl[9]  = '{"lduse",         mk(0,2,0,0, 1,1,2, 0,0, 0,0, 0), mx(0,0, 1,1,0,1, 0,0)};
        tbl[10] = '{"load_in_M",     mk(0,0,0,2, 0,0,0, 1,2, 0,0, 0), mx(0,2, 0,0,0,0, 1,0)};
        tbl[11] = '{"after_load",    idle,                              mx(0,0, 0,0,0,0, 0,0)};

        // reset state, with active inputs present
        vin   = busy;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        push("reset_a", 0, z);
        push("reset_b", 1, z);
        drain();
        vin   = idle;
        reset = 1'b0;
        cyc("post_reset_a", 0, idle, z);

        for (int i = 0; i < 12; i++)
            cyc(tbl[i].name, 0, tbl[i].v, tbl[i].e);

        // isolated branch: three flush cycles
        cyc("br_t0", 0, mk(0,0,0,0, 0,0,0, 0,0, 0,0, 1), mx(0,0, 0,0,1,1, 0,0));
        cyc("br_t1", 0, idle, mx(0,0, 0,0,1,1, 0,0));
        cyc("br_t2", 0, idle, mx(0,0, 0,0,1,1, 0,0));
        cyc("br_t3", 0, idle, z);
        cyc("br_t4", 0, idle, z);

        // second branch at t+1 restarts the penalty
        cyc("br2_t0", 0, mk(0,0,0,0, 0,0,0, 0,0, 0,0, 1), mx(0,0, 0,0,1,1, 0,0));
        cyc("br2_t1", 0, mk(0,0,0,0, 0,0,0, 0,0, 0,0, 1), mx(0,0, 0,0,1,1, 0,0));
        cyc("br2_t2", 0, idle, mx(0,0, 0,0,1,1, 0,0));
        cyc("br2_t3", 0, idle, mx(0,0, 0,0,1,1, 0,0));
        cyc("br2_t4", 0, idle, z);

        // branch overrides a simultaneous load-use stall
        cyc("br_lduse_t0", 0, mk(6,0,0,0, 1,1,6, 0,0, 0,0, 1), mx(0,0, 0,0,1,1, 0,0));
        cyc("br_lduse_t1", 0, mk(6,0,0,0, 1,1,6, 0,0, 0,0, 0), mx(0,0, 0,0,1,1, 0,0));
        cyc("br_lduse_t2", 0, idle, mx(0,0, 0,0,1,1, 0,0));
        cyc("br_lduse_t3", 0, idle, z);

        // reset in the middle of a flush
        cyc("rst_br_t0", 0, mk(0,0,0,0, 0,0,0, 0,0, 0,0, 1), mx(0,0, 0,0,1,1, 0,0));
        vin = idle;
        push("rst_br_t1", 0, mx(0,0, 0,0,1,1, 0,0));
        @(negedge clk);
        drain();
        #2;
        reset = 1'b1;
        vin   = busy;
        #1;
        push("rst_mid_a", 0, z);
        push("rst_mid_b", 1, z);
        drain();
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc("rst_rel_t0", 0, idle, z);
        cyc("rst_rel_t1", 0, idle, z);
        cyc("rst_rel_t2", 0, idle, z);

        // legacy instance: stall held while the producer walks E, M, W
        reset = 1'b1;
        #2;
        reset = 1'b0;
        cyc("leg_E", 1, mk(5,0,0,0, 1,0,5, 0,0, 0,0, 0), mx(0,0, 1,1,0,1, 0,0));
        cyc("leg_M", 1, mk(5,0,0,0, 0,0,0, 1,5, 0,0, 0), mx(0,0, 1,1,0,1, 1,0));
        cyc("leg_W", 1, mk(5,0,5,0, 0,0,0, 0,0, 1,5, 0), mx(0,0, 1,1,0,1, 2,0));
        cyc("leg_rel", 1, idle, mx(0,0, 0,0,0,0, 3,1));
        cyc("leg_clr", 1, idle, z);
        cyc("leg_pc",  1, mk(15,0,0,0, 0,0,0, 0,0, 1,15, 0), z);

        // legacy instance: watchdog saturation
        cyc("sat_0", 1, mk(0,9,0,0, 1,0,9, 0,0, 0,0, 0), mx(0,0, 1,1,0,1, 0,0));
        cyc("sat_1", 1, mk(0,9,0,0, 1,0,9, 0,0, 0,0, 0), mx(0,0, 1,1,0,1, 1,0));
        cyc("sat_2", 1, mk(0,9,0,0, 1,0,9, 0,0, 0,0, 0), mx(0,0, 1,1,0,1, 2,0));
        cyc("sat_3", 1, mk(0,9,0,0, 1,0,9, 0,0, 0,0, 0), mx(0,0, 1,1,0,1, 3,1));
        cyc("sat_4", 1, mk(0,9,0,0, 1,0,9, 0,0, 0,0, 0), mx(0,0, 1,1,0,1, 3,1));
        cyc("sat_rel", 1, idle, mx(0,0, 0,0,0,0, 3,1));
        cyc("sat_clr", 1, idle, z);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
